// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC and buffers {PC+step, instruction}
// pairs in a small FIFO so fetch keeps running while decode is frozen.
module if_fetch_queue #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       branch_taken,
  input  logic [ADDR_W-1:0]          branch_address,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       out_valid,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [DATA_W-1:0]          out_instruction,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0] pc_reg;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [DATA_W-1:0] ins_mem [DEPTH];

  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] pc_next;

  assign pc_next   = pc_reg + STEP;
  assign out_valid = (cnt != '0);
  assign pop       = out_valid & ~freeze & ~branch_taken;
  // A full queue still accepts a fetch when the head leaves in the same cycle.
  assign push      = ~branch_taken & ((cnt != FULL_CNT) | pop);

  // Control state: PC, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (branch_taken) begin
      pc_reg <= branch_address;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        pc_reg <= pc_next;
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Queue storage carries data only; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]  <= pc_next;
      ins_mem[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_addr       = pc_reg;
  assign count           = cnt;
  assign out_pc          = out_valid ? pc_mem[rd_ptr]  : '0;
  assign out_instruction = out_valid ? ins_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instruction;
  logic [2:0]  count;
  logic [31:0] key = 32'hA5A5_0000;

  int checks = 0;
  int failures = 0;

  logic [31:0] mpc;
  ent_t        mq[$];
  bit          chk_en = 1'b0;

  if_fetch_queue #(
    .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_address(branch_address), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_pc(out_pc),
    .out_instruction(out_instruction), .count(count)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ key;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, then advance the model by the same rules.
  task automatic step(input bit r, input bit f, input bit b, input logic [31:0] ba);
    bit do_pop, do_push;
    rst = r; freeze = f; branch_taken = b; branch_address = ba;
    @(posedge clk);
    if (r) begin
      mpc = 32'h0;
      mq.delete();
    end else if (b) begin
      mpc = ba;
      mq.delete();
    end else begin
      do_pop  = (mq.size() > 0) && !f;
      do_push = (mq.size() < DEPTH) || do_pop;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: mpc + 32'd4, ins: mpc ^ key});
        mpc = mpc + 32'd4;
      end
    end
    chk_en = 1'b1;
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("imem_addr", imem_addr, mpc);
      cmp("count", {29'd0, count}, mq.size());
      cmp("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      cmp("out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
      cmp("out_instruction", out_instruction, (mq.size() > 0) ? mq[0].ins : 32'h0);
    end
  end

  initial begin
    // Reset state and steady streaming.
    step(1, 0, 0, 0);
    cmp("lit_reset_addr", imem_addr, 32'h0);
    cmp("lit_reset_valid", {31'd0, out_valid}, 32'd0);
    cmp("lit_reset_pc", out_pc, 32'h0);
    step(0, 0, 0, 0);
    cmp("lit_first_pc", out_pc, 32'h4);
    cmp("lit_first_ins", out_instruction, 32'hA5A5_0000);
    step(0, 0, 0, 0);
    cmp("lit_second_pc", out_pc, 32'h8);
    cmp("lit_stream_count", {29'd0, count}, 32'd1);

    // Freeze fills the queue, then release drains in order.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0);
      if (i == 2) cmp("lit_freeze_addr3", imem_addr, 32'h10);
    end
    cmp("lit_frozen_count", {29'd0, count}, 32'd4);
    cmp("lit_frozen_addr", imem_addr, 32'h10);
    cmp("lit_frozen_head", out_pc, 32'h4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      cmp("lit_drain_head", out_pc, 32'h8 + 32'(4 * i));
      cmp("lit_drain_count", {29'd0, count}, 32'd4);
    end

    // Branch with three entries held and freeze active.
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    cmp("lit_pre_branch_count", {29'd0, count}, 32'd3);
    step(0, 1, 1, 32'h100);
    cmp("lit_branch_count", {29'd0, count}, 32'd0);
    cmp("lit_branch_addr", imem_addr, 32'h100);
    step(0, 0, 0, 0);
    cmp("lit_branch_target_pc", out_pc, 32'h104);

    // Reset dominates a simultaneous branch.
    step(1, 1, 1, 32'h200);
    cmp("lit_rst_over_branch", imem_addr, 32'h0);
    cmp("lit_rst_count", {29'd0, count}, 32'd0);

    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    cmp("lit_wrap_pc", out_pc, 32'h0);
    cmp("lit_wrap_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3 * DEPTH; i++) step(0, (i % 3) != 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      key = $urandom;
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 15) == 0, $urandom & 32'hFFFF_FFFC);
    end

    chk_en = 1'b0;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
